// File: rtl/bch_chien_search_if.sv
// Locator-in / position-flag-out bundle for bch_chien_search.
// The oerr_cnt member exists only when BCH_CHIEN_ERR_CNT_EN is defined.
interface bch_chien_search_if #(
  parameter int M = 4,
  parameter int T = 2
);
  logic              iloc_poly_val;
  logic [T:0][M-1:0] iloc_poly;
  logic [M-1:0]      iloc_poly_deg;
  logic              iloc_failed;
  logic              ordy;
  logic              oval;
  logic              osop;
  logic              oeop;
  logic              oerr;
  logic              odecfail;
`ifdef BCH_CHIEN_ERR_CNT_EN
  logic [M:0]        oerr_cnt;

  modport master (
    output iloc_poly_val, iloc_poly, iloc_poly_deg, iloc_failed,
    input  ordy, oval, osop, oeop, oerr, odecfail, oerr_cnt
  );
  modport slave (
    input  iloc_poly_val, iloc_poly, iloc_poly_deg, iloc_failed,
    output ordy, oval, osop, oeop, oerr, odecfail, oerr_cnt
  );
`else
  modport master (
    output iloc_poly_val, iloc_poly, iloc_poly_deg, iloc_failed,
    input  ordy, oval, osop, oeop, oerr, odecfail
  );
  modport slave (
    input  iloc_poly_val, iloc_poly, iloc_poly_deg, iloc_failed,
    output ordy, oval, osop, oeop, oerr, odecfail
  );
`endif
endinterface

// File: rtl/bch_chien_search.sv
// Chien search: evaluates the error locator at one codeword position per clock, highest degree first.
// Optional BCH_CHIEN_ERR_CNT_EN adds the oerr_cnt root-count output on the oeop beat.
module bch_chien_search #(
  parameter int M      = 4,
  parameter int N      = 15,
  parameter int T      = 2,
  parameter int IRRPOL = 19
) (
  input logic               iclk,
  input logic               ireset,
  bch_chien_search_if.slave bus
);

  localparam logic [M:0] POLY  = (M+1)'(IRRPOL);
  localparam int         QM    = (1 << M) - 1;
  localparam int         SHIFT = (1 << M) - N;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] v);
    logic [M:0] w;
    w = {v, 1'b0};
    if (w[M]) w = w ^ POLY;
    return w[M-1:0];
  endfunction

  // Constant-exponent multiply by alpha^k, unrolled into shift/reduce steps.
  function automatic logic [M-1:0] mul_alpha_pow(input logic [M-1:0] v, input int k);
    logic [M-1:0] acc;
    acc = v;
    for (int i = 0; i < QM; i++)
      if (i < (k % QM)) acc = mul_alpha(acc);
    return acc;
  endfunction

  logic [0:0]        state;
  logic [M-1:0]      pos;
  logic [M:0]        root_cnt;
  logic [M:0]        cnt_next;
  logic [M-1:0]      lam0;
  logic [M-1:0]      deg_q;
  logic              failed_q;
  logic [T:1][M-1:0] r;
  logic [T:1][M-1:0] r_load;
  logic [T:1][M-1:0] r_step;
  logic [M-1:0]      sum;
  logic              s_zero;
  logic              last;
  logic              decfail_next;
  logic              oval_q, osop_q, oeop_q, oerr_q, odecfail_q;
`ifdef BCH_CHIEN_ERR_CNT_EN
  logic [M:0]        cnt_out;
`endif

  // The load pre-rotates by alpha^(j*(2^M-N)) so a shortened code starts at degree N-1.
  for (genvar j = 1; j <= T; j++) begin : g_coef
    assign r_load[j] = mul_alpha_pow(bus.iloc_poly[j], j * SHIFT);
    assign r_step[j] = mul_alpha_pow(r[j], j);
  end

  always_comb begin
    sum = lam0;
    for (int j = 1; j <= T; j++) sum = sum ^ r[j];
  end

  assign s_zero = (sum == '0);
  assign last   = (pos == M'(N - 1));

  always_comb begin
    cnt_next = root_cnt;
    if (s_zero && (root_cnt != '1)) cnt_next = root_cnt + (M+1)'(1);
  end

  assign decfail_next = failed_q
                      | (cnt_next != {1'b0, deg_q})
                      | ({1'b0, deg_q} > (M+1)'(T));

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state      <= S_IDLE;
      pos        <= '0;
      root_cnt   <= '0;
      lam0       <= '0;
      deg_q      <= '0;
      failed_q   <= 1'b0;
      r          <= '0;
      oval_q     <= 1'b0;
      osop_q     <= 1'b0;
      oeop_q     <= 1'b0;
      oerr_q     <= 1'b0;
      odecfail_q <= 1'b0;
`ifdef BCH_CHIEN_ERR_CNT_EN
      cnt_out    <= '0;
`endif
    end else begin
      oval_q     <= 1'b0;
      osop_q     <= 1'b0;
      oeop_q     <= 1'b0;
      oerr_q     <= 1'b0;
      odecfail_q <= 1'b0;
`ifdef BCH_CHIEN_ERR_CNT_EN
      cnt_out    <= '0;
`endif
      case (state)
        S_IDLE: begin
          if (bus.iloc_poly_val) begin
            lam0     <= bus.iloc_poly[0];
            deg_q    <= bus.iloc_poly_deg;
            failed_q <= bus.iloc_failed;
            r        <= r_load;
            pos      <= '0;
            root_cnt <= '0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          oval_q   <= 1'b1;
          osop_q   <= (pos == '0);
          oeop_q   <= last;
          oerr_q   <= s_zero;
          root_cnt <= cnt_next;
          r        <= r_step;
          pos      <= pos + M'(1);
          if (last) begin
            odecfail_q <= decfail_next;
`ifdef BCH_CHIEN_ERR_CNT_EN
            cnt_out    <= cnt_next;
`endif
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ordy     = (state == S_IDLE);
  assign bus.oval     = oval_q;
  assign bus.osop     = osop_q;
  assign bus.oeop     = oeop_q;
  assign bus.oerr     = oerr_q;
  assign bus.odecfail = odecfail_q;
`ifdef BCH_CHIEN_ERR_CNT_EN
  assign bus.oerr_cnt = cnt_out;
`endif

endmodule

// File: tb/tb_bch_chien_search.sv
// Scoreboard bench for bch_chien_search: a full-length (N=15) and a shortened (N=10) instance,
// directed locators with hand-computed error positions, latency, overlap and reset-abort cases.
module tb_bch_chien_search;

  logic iclk;
  logic ireset;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    bit       sop;
    bit       eop;
    bit       err;
    bit       decfail;
    bit [4:0] cnt;
    int       cyc;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];

  bch_chien_search_if #(.M(4), .T(2)) bus_a ();
  bch_chien_search_if #(.M(4), .T(2)) bus_b ();

  bch_chien_search #(.M(4), .N(15), .T(2), .IRRPOL(19)) dut_a (
    .iclk   (iclk),
    .ireset (ireset),
    .bus    (bus_a)
  );

  bch_chien_search #(.M(4), .N(10), .T(2), .IRRPOL(19)) dut_b (
    .iclk   (iclk),
    .ireset (ireset),
    .bus    (bus_b)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  initial cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iclk);
      #1;
    end
  endtask

  task automatic checkSignal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare one output beat against the scoreboard entry, including its arrival cycle.
  task automatic checkOutput(input string name, input beat_t b, input logic s, input logic e,
                             input logic er, input logic df, input logic [4:0] ac);
    logic [8:0] act;
    logic [8:0] expv;
`ifdef BCH_CHIEN_ERR_CNT_EN
    act  = {s, e, er, df, ac};
    expv = {b.sop, b.eop, b.err, b.decfail, b.cnt};
`else
    act  = {s, e, er, df, 5'd0};
    expv = {b.sop, b.eop, b.err, b.decfail, 5'd0};
`endif
    checks++;
    if (act !== expv || cyc != b.cyc) begin
      errors++;
      $display("[TB] FAIL %s beat: got sop/eop/err/df/cnt=%b at cycle %0d, expected %b at cycle %0d",
               name, act, cyc, expv, b.cyc);
    end
  endtask

  // Pulse one strobe; when the strobe should be accepted, queue the N expected beats first.
  task automatic applyStimulus(input int which, input logic [3:0] l0, input logic [3:0] l1,
                               input logic [3:0] l2, input logic [3:0] deg, input logic failed,
                               input int n, input logic [14:0] mask, input logic dfail,
                               input logic [4:0] cnt, input bit accept);
    beat_t b;
    if (accept) begin
      for (int p = 0; p < n; p++) begin
        b.sop     = (p == 0);
        b.eop     = (p == n - 1);
        b.err     = mask[p];
        b.decfail = (p == n - 1) ? dfail : 1'b0;
        b.cnt     = (p == n - 1) ? cnt : 5'd0;
        b.cyc     = cyc + 2 + p;
        if (which == 0) qa.push_back(b);
        else qb.push_back(b);
      end
    end
    if (which == 0) begin
      bus_a.iloc_poly     = {l2, l1, l0};
      bus_a.iloc_poly_deg = deg;
      bus_a.iloc_failed   = failed;
      bus_a.iloc_poly_val = 1'b1;
    end else begin
      bus_b.iloc_poly     = {l2, l1, l0};
      bus_b.iloc_poly_deg = deg;
      bus_b.iloc_failed   = failed;
      bus_b.iloc_poly_val = 1'b1;
    end
    tick(1);
    bus_a.iloc_poly_val = 1'b0;
    bus_b.iloc_poly_val = 1'b0;
  endtask

  task automatic waitDrain(input int which, input int max_cycles);
    int k;
    k = 0;
    while (((which == 0) ? qa.size() : qb.size()) != 0 && k < max_cycles) begin
      tick(1);
      k++;
    end
    checkSignal((which == 0) ? "drain_a" : "drain_b",
                (which == 0) ? qa.size() : qb.size(), 0);
    tick(2);
  endtask

  always @(negedge iclk) begin
    if (bus_a.oval === 1'b1) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat dutA: got oval=1 oeop=%b at cycle %0d, expected no beat",
                 bus_a.oeop, cyc);
      end else begin
`ifdef BCH_CHIEN_ERR_CNT_EN
        checkOutput("dutA", qa.pop_front(), bus_a.osop, bus_a.oeop, bus_a.oerr, bus_a.odecfail,
                    bus_a.oerr_cnt);
`else
        checkOutput("dutA", qa.pop_front(), bus_a.osop, bus_a.oeop, bus_a.oerr, bus_a.odecfail,
                    5'd0);
`endif
      end
    end
  end

  always @(negedge iclk) begin
    if (bus_b.oval === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat dutB: got oval=1 oeop=%b at cycle %0d, expected no beat",
                 bus_b.oeop, cyc);
      end else begin
`ifdef BCH_CHIEN_ERR_CNT_EN
        checkOutput("dutB", qb.pop_front(), bus_b.osop, bus_b.oeop, bus_b.oerr, bus_b.odecfail,
                    bus_b.oerr_cnt);
`else
        checkOutput("dutB", qb.pop_front(), bus_b.osop, bus_b.oeop, bus_b.oerr, bus_b.odecfail,
                    5'd0);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    ireset = 1'b1;
    bus_a.iloc_poly_val = 1'b0;
    bus_a.iloc_poly     = '0;
    bus_a.iloc_poly_deg = '0;
    bus_a.iloc_failed   = 1'b0;
    bus_b.iloc_poly_val = 1'b0;
    bus_b.iloc_poly     = '0;
    bus_b.iloc_poly_deg = '0;
    bus_b.iloc_failed   = 1'b0;
    tick(3);

    checkSignal("reset_ordy_a", int'(bus_a.ordy), 1);
    checkSignal("reset_oval_a", int'(bus_a.oval), 0);
    checkSignal("reset_flags_a", int'({bus_a.osop, bus_a.oeop, bus_a.oerr, bus_a.odecfail}), 0);
    checkSignal("reset_ordy_b", int'(bus_b.ordy), 1);
`ifdef BCH_CHIEN_ERR_CNT_EN
    checkSignal("reset_cnt_a", int'(bus_a.oerr_cnt), 0);
`endif
    ireset = 1'b0;
    tick(2);

    $display("[TB] no-error locator");
    applyStimulus(0, 4'd1, 4'd0, 4'd0, 4'd0, 1'b0, 15, 15'h0000, 1'b0, 5'd0, 1'b1);
    waitDrain(0, 40);

    $display("[TB] single error at degree 3");
    applyStimulus(0, 4'd1, 4'd8, 4'd0, 4'd1, 1'b0, 15, 15'h0800, 1'b0, 5'd1, 1'b1);
    waitDrain(0, 40);

    $display("[TB] two errors at degrees 0 and 5");
    applyStimulus(0, 4'd1, 4'd7, 4'd6, 4'd2, 1'b0, 15, 15'h4200, 1'b0, 5'd2, 1'b1);
    waitDrain(0, 40);

    $display("[TB] all-zero locator");
    applyStimulus(0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 15, 15'h7FFF, 1'b1, 5'd15, 1'b1);
    waitDrain(0, 40);

    $display("[TB] shortened code, root outside the codeword");
    applyStimulus(1, 4'd1, 4'd14, 4'd15, 4'd2, 1'b0, 10, 15'h0200, 1'b1, 5'd1, 1'b1);
    waitDrain(1, 40);

    $display("[TB] shortened code, solver failed");
    applyStimulus(1, 4'd1, 4'd0, 4'd0, 4'd0, 1'b1, 10, 15'h0000, 1'b1, 5'd0, 1'b1);
    waitDrain(1, 40);

    $display("[TB] strobe during run, then strobe right after oeop");
    applyStimulus(0, 4'd1, 4'd7, 4'd6, 4'd2, 1'b0, 15, 15'h4200, 1'b0, 5'd2, 1'b1);
    tick(6);
    checkSignal("ordy_busy", int'(bus_a.ordy), 0);
    applyStimulus(0, 4'd1, 4'd8, 4'd0, 4'd1, 1'b0, 15, 15'h0000, 1'b0, 5'd0, 1'b0);
    tick(9);
    checkSignal("ordy_after_eop", int'(bus_a.ordy), 1);
    applyStimulus(0, 4'd1, 4'd8, 4'd0, 4'd1, 1'b0, 15, 15'h0800, 1'b0, 5'd1, 1'b1);
    waitDrain(0, 40);

    $display("[TB] reset mid-run");
    applyStimulus(0, 4'd1, 4'd8, 4'd0, 4'd1, 1'b0, 15, 15'h0800, 1'b0, 5'd1, 1'b1);
    tick(8);
    ireset = 1'b1;
    tick(1);
    qa.delete();
    checkSignal("abort_oval", int'(bus_a.oval), 0);
    checkSignal("abort_ordy", int'(bus_a.ordy), 1);
    ireset = 1'b0;
    tick(20);
    applyStimulus(0, 4'd1, 4'd7, 4'd6, 4'd2, 1'b0, 15, 15'h4200, 1'b0, 5'd2, 1'b1);
    waitDrain(0, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
